multi_mode_counter: RTL and testbench

Parametrised successor to the lab's two-bit counter: a WIDTH-bit modulo counter with four modes chosen by `select`: up, down, bounce (ping-pong) and parallel load. It adds a programmable modulus, a direction state machine and a registered terminal-count pulse. It sits in the FSM lab datapath as the general-purpose sequencer, and its `Counter_Out` drives downstream state decoders.

---
 rtl/counter_pkg.sv | 15 +
 rtl/multi_mode_counter.sv | 101 ++++++++++
 tb/tb_multi_mode_counter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared constants for the multi-mode counter: mode select codes and the
// bounce direction state encoding.
package counter_pkg;

  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_LOAD   = 2'b11;

  typedef enum logic {
    S_UP   = 1'b0,
    S_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/multi_mode_counter.sv
// WIDTH-bit modulo counter with up, down, bounce and load modes, a
// programmable modulus and a registered one-cycle terminal-count pulse.
module multi_mode_counter
  import counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = (1 << WIDTH) - 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic [1:0]       select,
  input  logic [WIDTH-1:0] Load_Value,
  output logic [WIDTH-1:0] Counter_Out,
  output logic             Dir,
  output logic             out1
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam bit               DEGENERATE = (MAX_COUNT == 0);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_next;
  dir_e             dir_q;
  dir_e             dir_next;
  logic             pulse_q;
  logic             pulse_next;

  always_comb begin
    count_next = count_q;
    dir_next   = dir_q;
    pulse_next = 1'b0;
    if (En) begin
      case (select)
        MODE_UP: begin
          dir_next = S_UP;
          if (count_q == MAX_VAL) begin
            count_next = '0;
            pulse_next = 1'b1;
          end else begin
            count_next = count_q + ONE;
          end
        end
        MODE_DOWN: begin
          dir_next = S_DOWN;
          if (count_q == '0) begin
            count_next = MAX_VAL;
            pulse_next = 1'b1;
          end else begin
            count_next = count_q - ONE;
          end
        end
        MODE_BOUNCE: begin
          // With a zero modulus there is nowhere to move, so each edge is a turn.
          if (DEGENERATE) begin
            count_next = '0;
            dir_next   = (dir_q == S_UP) ? S_DOWN : S_UP;
            pulse_next = 1'b1;
          end else if (dir_q == S_UP) begin
            if (count_q == MAX_VAL) begin
              count_next = MAX_VAL - ONE;
              dir_next   = S_DOWN;
              pulse_next = 1'b1;
            end else begin
              count_next = count_q + ONE;
            end
          end else begin
            if (count_q == '0) begin
              count_next = ONE;
              dir_next   = S_UP;
              pulse_next = 1'b1;
            end else begin
              count_next = count_q - ONE;
            end
          end
        end
        default: begin
          count_next = (Load_Value > MAX_VAL) ? MAX_VAL : Load_Value;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      count_q <= '0;
      dir_q   <= S_UP;
      pulse_q <= 1'b0;
    end else begin
      count_q <= count_next;
      dir_q   <= dir_next;
      pulse_q <= pulse_next;
    end
  end

  assign Counter_Out = count_q;
  assign Dir         = dir_q;
  assign out1        = pulse_q;

endmodule

// File: tb/tb_multi_mode_counter.sv
// Directed-vector bench for multi_mode_counter: a WIDTH=4/MAX_COUNT=9 unit
// and a MAX_COUNT=0 unit driven by the same stimulus.
module tb_multi_mode_counter;

  logic       clk;
  logic       rstN;
  logic       en;
  logic [1:0] sel;
  logic [3:0] loadValue;
  logic [3:0] counterOut;
  logic       dir;
  logic       termPulse;
  logic [3:0] counterOutZero;
  logic       dirZero;
  logic       termPulseZero;

  int compareCount  = 0;
  int mismatchCount = 0;

  int bounceCnt[20] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};

  multi_mode_counter #(.WIDTH(4), .MAX_COUNT(9)) dut (
    .Clk(clk), .Reset(rstN), .En(en), .select(sel), .Load_Value(loadValue),
    .Counter_Out(counterOut), .Dir(dir), .out1(termPulse)
  );

  multi_mode_counter #(.WIDTH(4), .MAX_COUNT(0)) dutZero (
    .Clk(clk), .Reset(rstN), .En(en), .select(sel), .Load_Value(loadValue),
    .Counter_Out(counterOutZero), .Dir(dirZero), .out1(termPulseZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic e, input logic [1:0] s,
                               input logic [3:0] lv);
    rstN      = r;
    en        = e;
    sel       = s;
    loadValue = lv;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input int expCnt, input int expDir,
                          input int expPulse);
    checkOutput({tag, " cnt"}, int'(counterOut), expCnt);
    checkOutput({tag, " dir"}, int'(dir), expDir);
    checkOutput({tag, " out1"}, int'(termPulse), expPulse);
  endtask

  initial begin
    rstN = 1'b0; en = 1'b1; sel = 2'b00; loadValue = 4'd0;

    // Reset overrides an enabled up count, then counting resumes
    applyStimulus(1'b0, 1'b1, 2'b00, 4'd0);
    applyStimulus(1'b0, 1'b1, 2'b00, 4'd0);
    checkAll("reset", 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b1, 1'b1, 2'b00, 4'd0);
      checkAll($sformatf("resume%0d", i), i, 0, 0);
    end

    // Up wrap
    applyStimulus(1'b1, 1'b1, 2'b11, 4'd8);
    checkAll("load8", 8, 0, 0);
    applyStimulus(1'b1, 1'b1, 2'b00, 4'd0);
    checkAll("up9", 9, 0, 0);
    applyStimulus(1'b1, 1'b1, 2'b00, 4'd0);
    checkAll("upwrap", 0, 0, 1);
    applyStimulus(1'b1, 1'b1, 2'b00, 4'd0);
    checkAll("upafter", 1, 0, 0);

    // Bounce sweep starting in S_UP from 0
    applyStimulus(1'b1, 1'b1, 2'b11, 4'd0);
    checkAll("load0", 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b1, 2'b10, 4'd0);
      checkAll($sformatf("bounce%0d", i), bounceCnt[i],
               (i >= 9 && i <= 17) ? 1 : 0, (i == 9 || i == 18) ? 1 : 0);
    end

    // Down wrap
    applyStimulus(1'b1, 1'b1, 2'b11, 4'd1);
    checkAll("load1", 1, 0, 0);
    applyStimulus(1'b1, 1'b1, 2'b01, 4'd0);
    checkAll("down0", 0, 1, 0);
    applyStimulus(1'b1, 1'b1, 2'b01, 4'd0);
    checkAll("downwrap", 9, 1, 1);

    // Load saturation, then hold with En low
    applyStimulus(1'b1, 1'b1, 2'b11, 4'd13);
    checkAll("loadsat", 9, 1, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 2'b00, 4'd2);
      checkAll($sformatf("hold%0d", i), 9, 1, 0);
    end

    // Mode change up -> down at count 5
    applyStimulus(1'b1, 1'b1, 2'b11, 4'd4);
    checkAll("load4", 4, 1, 0);
    applyStimulus(1'b1, 1'b1, 2'b00, 4'd0);
    checkAll("upto5", 5, 0, 0);
    applyStimulus(1'b1, 1'b1, 2'b01, 4'd0);
    checkAll("modechg", 4, 1, 0);

    // Reset mid-bounce while in S_DOWN at 6
    applyStimulus(1'b1, 1'b1, 2'b11, 4'd7);
    checkAll("load7", 7, 1, 0);
    applyStimulus(1'b1, 1'b1, 2'b10, 4'd0);
    checkAll("bdown6", 6, 1, 0);
    applyStimulus(1'b0, 1'b1, 2'b10, 4'd0);
    checkAll("midreset", 0, 0, 0);
    applyStimulus(1'b1, 1'b1, 2'b10, 4'd0);
    checkAll("bresume1", 1, 0, 0);
    applyStimulus(1'b1, 1'b1, 2'b10, 4'd0);
    checkAll("bresume2", 2, 0, 0);

    // Degenerate modulus unit: the two bounce edges above toggled Dir 0->1->0
    checkOutput("zero bdir", int'(dirZero), 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 2'b00, 4'd0);
      checkOutput($sformatf("zero up%0d cnt", i), int'(counterOutZero), 0);
      checkOutput($sformatf("zero up%0d out1", i), int'(termPulseZero), 1);
    end
    applyStimulus(1'b1, 1'b1, 2'b10, 4'd0);
    checkOutput("zero bounce dir", int'(dirZero), 1);
    checkOutput("zero bounce out1", int'(termPulseZero), 1);
    applyStimulus(1'b1, 1'b1, 2'b11, 4'd15);
    checkOutput("zero load cnt", int'(counterOutZero), 0);
    checkOutput("zero load out1", int'(termPulseZero), 0);
    applyStimulus(1'b1, 1'b0, 2'b00, 4'd0);
    checkOutput("zero hold out1", int'(termPulseZero), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
